// File: rtl/status_select_capture.sv
// Per-bit select between two low fields, concatenated with a pass-through upper field,
// registered with change detection, a one-entry snapshot port, a saturating counter and sticky overflow.
// Optional STATUS_SYNC_EN: adds 2-flop synchronisers on src_a, src_b and hi_in.
module status_select_capture #(
  parameter int WIDTH = 4,
  parameter int HI_W  = 6,
  parameter int CNT_W = 8
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        sel,
  input  logic [WIDTH-1:0]        src_a,
  input  logic [WIDTH-1:0]        src_b,
  input  logic [HI_W-1:0]         hi_in,
  input  logic                    capture_en,
  input  logic                    snap_ready,
  input  logic                    ovf_clr,
  output logic [HI_W+WIDTH-1:0]   status_q,
  output logic                    snap_valid,
  output logic [HI_W+WIDTH-1:0]   snap_data,
  output logic [CNT_W-1:0]        change_cnt,
  output logic                    overflow
);

  localparam int SW = HI_W + WIDTH;

  logic [WIDTH-1:0] a_use;
  logic [WIDTH-1:0] b_use;
  logic [HI_W-1:0]  hi_use;

`ifdef STATUS_SYNC_EN
  // sel and capture_en are deliberately left unsynchronised.
  logic [WIDTH-1:0] a_meta_q, a_sync_q, b_meta_q, b_sync_q;
  logic [HI_W-1:0]  hi_meta_q, hi_sync_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      a_meta_q  <= '0;
      a_sync_q  <= '0;
      b_meta_q  <= '0;
      b_sync_q  <= '0;
      hi_meta_q <= '0;
      hi_sync_q <= '0;
    end else begin
      a_meta_q  <= src_a;
      a_sync_q  <= a_meta_q;
      b_meta_q  <= src_b;
      b_sync_q  <= b_meta_q;
      hi_meta_q <= hi_in;
      hi_sync_q <= hi_meta_q;
    end
  end

  assign a_use  = a_sync_q;
  assign b_use  = b_sync_q;
  assign hi_use = hi_sync_q;
`else
  assign a_use  = src_a;
  assign b_use  = src_b;
  assign hi_use = hi_in;
`endif

  logic [SW-1:0]    status_d;
  logic [SW-1:0]    snap_data_q, snap_data_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
  logic             overflow_q, overflow_d;
  logic [SW-1:0]    next_word;
  logic             change_evt;
  logic             hs;

  always_comb begin
    next_word    = {hi_use, (sel & a_use) | (~sel & b_use)};
    change_evt   = capture_en && (next_word != status_q);
    hs           = snap_valid_q && snap_ready;
    status_d     = capture_en ? next_word : status_q;
    change_cnt_d = change_cnt_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    overflow_d   = overflow_q && !ovf_clr;

    if (change_evt && (change_cnt_q != {CNT_W{1'b1}}))
      change_cnt_d = change_cnt_q + 1'b1;

    // A drop sets overflow even when ovf_clr is asserted in the same cycle.
    if (change_evt) begin
      if (!snap_valid_q || hs) begin
        snap_data_d  = next_word;
        snap_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (hs) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      status_q     <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      change_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      status_q     <= status_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      change_cnt_q <= change_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign change_cnt = change_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_status_select_capture.sv
// Directed self-checking bench for status_select_capture (default build, sync disabled).
module tb_status_select_capture;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [3:0] sel, src_a, src_b;
  logic [5:0] hi_in;
  logic       capture_en, snap_ready, ovf_clr;
  logic [9:0] status_q, snap_data;
  logic       snap_valid, overflow;
  logic [7:0] change_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 sysclk = ~sysclk;

  status_select_capture #(.WIDTH(4), .HI_W(6), .CNT_W(8)) dut (
    .sysclk(sysclk), .reset(reset), .sel(sel), .src_a(src_a), .src_b(src_b),
    .hi_in(hi_in), .capture_en(capture_en), .snap_ready(snap_ready), .ovf_clr(ovf_clr),
    .status_q(status_q), .snap_valid(snap_valid), .snap_data(snap_data),
    .change_cnt(change_cnt), .overflow(overflow)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sel = 4'h0; src_a = 4'h0; src_b = 4'h0; hi_in = 6'h00;
    capture_en = 1'b0; snap_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    vectors++; if (status_q !== 10'h000) begin errors++; $display("FAIL rst_status got %h exp 000", status_q); end
    vectors++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", snap_valid); end
    vectors++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h exp 00", change_cnt); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    step();
    reset = 1'b1;
    step();
    vectors++; if (status_q !== 10'h000) begin errors++; $display("FAIL idle_status got %h exp 000", status_q); end
    $display("reset: status=%h valid=%b cnt=%h", status_q, snap_valid, change_cnt);
  endtask

  task automatic test_first_capture(input logic [7:0] exp_cnt);
    sel = 4'hA; src_a = 4'hF; src_b = 4'h0; hi_in = 6'h15; capture_en = 1'b1; snap_ready = 1'b0;
    step();
    vectors++; if (status_q !== 10'h15A) begin errors++; $display("FAIL first_status got %h exp 15a", status_q); end
    vectors++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", snap_valid); end
    vectors++; if (snap_data !== 10'h15A) begin errors++; $display("FAIL first_data got %h exp 15a", snap_data); end
    vectors++; if (change_cnt !== exp_cnt) begin errors++; $display("FAIL first_cnt got %h exp %h", change_cnt, exp_cnt); end
    $display("first capture: status=%h data=%h cnt=%h", status_q, snap_data, change_cnt);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (change_cnt !== 8'h01) begin errors++; $display("FAIL hold_cnt[%0d] got %h exp 01", i, change_cnt); end
      vectors++; if (snap_data !== 10'h15A) begin errors++; $display("FAIL hold_data[%0d] got %h exp 15a", i, snap_data); end
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL hold_ovf[%0d] got %b exp 0", i, overflow); end
      $display("hold %0d: cnt=%h data=%h ovf=%b", i, change_cnt, snap_data, overflow);
    end
  endtask

  task automatic test_drop();
    src_b = 4'h5;
    step();
    vectors++; if (status_q !== 10'h15F) begin errors++; $display("FAIL drop_status got %h exp 15f", status_q); end
    vectors++; if (change_cnt !== 8'h02) begin errors++; $display("FAIL drop_cnt got %h exp 02", change_cnt); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b exp 1", overflow); end
    vectors++; if (snap_data !== 10'h15A) begin errors++; $display("FAIL drop_data got %h exp 15a", snap_data); end
    $display("drop: status=%h cnt=%h ovf=%b data=%h", status_q, change_cnt, overflow, snap_data);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    $display("ovf_clr: ovf=%b", overflow);
  endtask

  task automatic test_handshake();
    snap_ready = 1'b1; src_b = 4'h0;
    step();
    vectors++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL hs_evt_valid got %b exp 1", snap_valid); end
    vectors++; if (snap_data !== 10'h15A) begin errors++; $display("FAIL hs_evt_data got %h exp 15a", snap_data); end
    vectors++; if (change_cnt !== 8'h03) begin errors++; $display("FAIL hs_evt_cnt got %h exp 03", change_cnt); end
    $display("hs+event: valid=%b data=%h cnt=%h", snap_valid, snap_data, change_cnt);
    step();
    vectors++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL hs_drain_valid got %b exp 0", snap_valid); end
    vectors++; if (snap_data !== 10'h15A) begin errors++; $display("FAIL hs_drain_data got %h exp 15a", snap_data); end
    snap_ready = 1'b0;
    $display("drain: valid=%b data=%h", snap_valid, snap_data);
  endtask

  task automatic test_capture_disable();
    capture_en = 1'b0; sel = 4'h0; src_b = 4'h3;
    step();
    vectors++; if (status_q !== 10'h15A) begin errors++; $display("FAIL dis_status got %h exp 15a", status_q); end
    vectors++; if (change_cnt !== 8'h03) begin errors++; $display("FAIL dis_cnt got %h exp 03", change_cnt); end
    vectors++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b exp 0", snap_valid); end
    $display("capture off: status=%h cnt=%h", status_q, change_cnt);
    capture_en = 1'b1;
    step();
    vectors++; if (status_q !== 10'h153) begin errors++; $display("FAIL en_status got %h exp 153", status_q); end
    vectors++; if (snap_data !== 10'h153) begin errors++; $display("FAIL en_data got %h exp 153", snap_data); end
    vectors++; if (change_cnt !== 8'h04) begin errors++; $display("FAIL en_cnt got %h exp 04", change_cnt); end
    $display("capture on: status=%h data=%h cnt=%h", status_q, snap_data, change_cnt);
  endtask

  task automatic test_set_wins();
    ovf_clr = 1'b1; src_b = 4'h4;
    step();
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL setwins_ovf got %b exp 1", overflow); end
    vectors++; if (snap_data !== 10'h153) begin errors++; $display("FAIL setwins_data got %h exp 153", snap_data); end
    vectors++; if (change_cnt !== 8'h05) begin errors++; $display("FAIL setwins_cnt got %h exp 05", change_cnt); end
    $display("drop+clr: ovf=%b data=%h cnt=%h", overflow, snap_data, change_cnt);
    step();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL setwins_clr got %b exp 0", overflow); end
    $display("clr only: ovf=%b", overflow);
  endtask

  task automatic test_mux_pattern();
    // mixed = (5&3)|(A&C) = 1|8 = 9 ; {6'h2A,4'h9} = 10'h2A9
    sel = 4'h5; src_a = 4'h3; src_b = 4'hC; hi_in = 6'h2A; snap_ready = 1'b1;
    step();
    snap_ready = 1'b0;
    vectors++; if (status_q !== 10'h2A9) begin errors++; $display("FAIL mux_status got %h exp 2a9", status_q); end
    vectors++; if (snap_data !== 10'h2A9) begin errors++; $display("FAIL mux_data got %h exp 2a9", snap_data); end
    vectors++; if (change_cnt !== 8'h06) begin errors++; $display("FAIL mux_cnt got %h exp 06", change_cnt); end
    $display("mux: status=%h data=%h cnt=%h", status_q, snap_data, change_cnt);
  endtask

  task automatic test_saturate();
    int exp_cnt;
    sel = 4'hA; src_b = 4'h0; hi_in = 6'h15;
    for (int i = 0; i < 303; i++) begin
      src_a = (i % 2 == 0) ? 4'hF : 4'hD;
      step();
      exp_cnt = (6 + i + 1 > 255) ? 255 : 6 + i + 1;
      vectors++; if (change_cnt !== exp_cnt[7:0]) begin errors++; $display("FAIL sat_cnt[%0d] got %h exp %h", i, change_cnt, exp_cnt[7:0]); end
      $display("toggle %0d: status=%h cnt=%h", i, status_q, change_cnt);
    end
  endtask

  task automatic test_async_reset();
    vectors++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", snap_valid); end
    @(negedge sysclk);
    #1 reset = 1'b0;
    #1;
    vectors++; if (status_q !== 10'h000) begin errors++; $display("FAIL arst_status got %h exp 000", status_q); end
    vectors++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", snap_valid); end
    vectors++; if (snap_data !== 10'h000) begin errors++; $display("FAIL arst_data got %h exp 000", snap_data); end
    vectors++; if (change_cnt !== 8'h00) begin errors++; $display("FAIL arst_cnt got %h exp 00", change_cnt); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b exp 0", overflow); end
    $display("async reset: status=%h valid=%b data=%h cnt=%h ovf=%b", status_q, snap_valid, snap_data, change_cnt, overflow);
    step();
    vectors++; if (status_q !== 10'h000) begin errors++; $display("FAIL arst_held got %h exp 000", status_q); end
    reset = 1'b1; capture_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_capture(8'h01);
    test_hold();
    test_drop();
    test_handshake();
    test_capture_disable();
    test_set_wins();
    test_mux_pattern();
    test_saturate();
    test_async_reset();
    test_first_capture(8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
